d_flipflop: RTL and testbench

// - Edge-triggered D-type storage element: samples D on every rising CLK edge
//   and presents it on Q until the next rising edge.
// - Synchronous, active-high RESET forces Q to a known value.
// - Leaf primitive for registering control bits and single-bit datapath signals.
// - Parameters allow widening and extra delay stages. Defaults give exactly one
//   1-bit flip-flop.
//

---
 rtl/d_flipflop.sv | 36 +++
 tb/tb_d_flipflop.sv | 132 +++++++++++++
 2 files changed

// File: rtl/d_flipflop.sv
// Parameterised D-type register chain: WIDTH bits wide, STAGES deep,
// with a synchronous active-high reset that loads RESET_VAL into every stage.
module d_flipflop #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int STAGES = 1
) (
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] Q
);

  if (STAGES < 1) begin : g_bad_stages
    $error("d_flipflop: STAGES must be >= 1");
  end

  logic [WIDTH-1:0] stage [STAGES];

  // Reset discards everything in flight, not just the output stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= D;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign Q = stage[STAGES-1];

endmodule

// File: tb/tb_d_flipflop.sv
// Randomised bench for d_flipflop: default instance plus an 8-bit,
// 3-stage instance, both checked against a history-based reference.
module tb_d_flipflop;

  logic       CLK;
  logic       r1;
  logic       d1;
  logic       q1;
  logic       r8;
  logic [7:0] d8;
  logic [7:0] q8;

  int n_cmp = 0;
  int n_err = 0;

  logic       rst_h1 [$];
  logic       d_h1   [$];
  logic       rst_h8 [$];
  logic [7:0] d_h8   [$];

  d_flipflop u_dff (
    .D(d1), .CLK(CLK), .RESET(r1), .Q(q1)
  );

  d_flipflop #(
    .WIDTH(8), .RESET_VAL(8'hA5), .STAGES(3)
  ) u_pipe (
    .D(d8), .CLK(CLK), .RESET(r8), .Q(q8)
  );

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  // Q after edge n is D from edge n-S+1, unless any of the last S
  // edges saw reset, in which case it is the reset value.
  function automatic logic [7:0] model8();
    int n = rst_h8.size();
    for (int k = n - 3; k < n; k++)
      if (rst_h8[k]) return 8'hA5;
    return d_h8[n-3];
  endfunction

  function automatic logic model1();
    int n = rst_h1.size();
    if (rst_h1[n-1]) return 1'b0;
    return d_h1[n-1];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/q1"}, {7'b0, q1}, {7'b0, model1()});
    if (rst_h8.size() >= 3)
      chk({tag, "/q8"}, q8, model8());
  endtask

  // One clock cycle: inputs set in the low phase, checked after the
  // edge, then D glitched twice before the next edge.
  task automatic step(input string tag, input logic rs1, input logic dv1,
                      input logic rs8, input logic [7:0] dv8);
    r1 = rs1;
    d1 = dv1;
    r8 = rs8;
    d8 = dv8;
    @(posedge CLK);
    rst_h1.push_back(rs1);
    d_h1.push_back(dv1);
    rst_h8.push_back(rs8);
    d_h8.push_back(dv8);
    #1;
    check_all(tag);
    #4;
    d1 = ~d1;
    d8 = 8'($urandom);
    r1 = 1'($urandom);
    r8 = 1'($urandom);
    #2;
    check_all({tag, "-hi"});
    @(negedge CLK);
    d1 = ~d1;
    d8 = 8'($urandom);
    #2;
    check_all({tag, "-lo"});
  endtask

  initial begin
    // T1 reset held for five edges (10..90 ns)
    for (int i = 0; i < 5; i++) step("t1_reset", 1'b1, 1'b0, 1'b1, 8'h00);
    // T2 capture / T6 pipeline: 0xA5 for two edges then 0x3C
    step("t2_cap", 1'b0, 1'b1, 1'b0, 8'h3C);
    chk("t6_a5_1", q8, 8'hA5);
    step("t2_hold", 1'b0, 1'b1, 1'b0, 8'h3C);
    chk("t6_a5_2", q8, 8'hA5);
    step("t2_hold", 1'b0, 1'b1, 1'b0, 8'h3C);
    chk("t6_3c", q8, 8'h3C);
    chk("t2_q1", {7'b0, q1}, 8'h01);
    // T3 toggle
    step("t3_d0", 1'b0, 1'b0, 1'b0, 8'h11);
    chk("t3_q0", {7'b0, q1}, 8'h00);
    step("t3_d1", 1'b0, 1'b1, 1'b0, 8'h22);
    chk("t3_q1", {7'b0, q1}, 8'h01);
    step("t3_d1", 1'b0, 1'b1, 1'b0, 8'h33);
    // T4 reset priority over D, mid-flight flush of the pipeline
    step("t4_rst", 1'b1, 1'b1, 1'b1, 8'hFF);
    chk("t4_q0", {7'b0, q1}, 8'h00);
    chk("t4_flush", q8, 8'hA5);
    step("t4_rel", 1'b0, 1'b1, 1'b0, 8'h5A);
    chk("t4_q1", {7'b0, q1}, 8'h01);
    step("t4_rel2", 1'b0, 1'b0, 1'b0, 8'h6B);
    step("t4_rel3", 1'b0, 1'b1, 1'b0, 8'h7C);
    chk("t4_pipe", q8, 8'h5A);
    // Random traffic with occasional resets (T5 glitches in every step)
    for (int i = 0; i < 300; i++) begin
      step("rand",
           1'($urandom_range(0, 9) == 0), 1'($urandom),
           1'($urandom_range(0, 11) == 0), 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
